// File: rtl/ldl_cdc_hand_rx_v1.sv
// Receive side of a 2-phase (toggle) req/ack CDC handshake: synchronizes req_tgl,
// waits SETTLE cycles, captures din, presents it as a valid/ready word, acks on accept.
// Latency LEVEL+1+SETTLE rx_clk edges from req_tgl sampling to dout_vld; holds word while dout_rdy=0.
//
// Ports:
//   rx_clk   - sole clock (rising edge)
//   rx_rst   - asynchronous active-low reset
//   req_tgl  - 2-phase request from the foreign domain (asynchronous)
//   din      - foreign data, stable from req toggle until the matching ack toggle
//   ack_tgl  - registered 2-phase acknowledge back to the foreign domain
//   dout     - captured data (registered), dout_vld / dout_rdy handshake
//   err      - sticky protocol error (only with LDL_CDC_HAND_RX_ERR_EN defined)
//   err_clr  - clears err (only with LDL_CDC_HAND_RX_ERR_EN defined)
// Optional feature macro: LDL_CDC_HAND_RX_ERR_EN
module ldl_cdc_hand_rx_v1 #(
    parameter int DW     = 8,
    parameter int LEVEL  = 2,
    parameter int SETTLE = 1
) (
    input  logic          rx_clk,
    input  logic          rx_rst,
    input  logic          req_tgl,
    input  logic [DW-1:0] din,
    output logic          ack_tgl,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy
`ifdef LDL_CDC_HAND_RX_ERR_EN
    ,
    output logic          err,
    input  logic          err_clr
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

    logic [LEVEL-1:0] r_sync;
    logic             r_req_seen;
    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [DW-1:0]    r_dout;
    logic             r_dout_vld;
    logic             r_ack;

    state_t           w_state_nxt;
    logic [7:0]       w_cnt_nxt;
    logic             w_seen_nxt;
    logic [DW-1:0]    w_dout_nxt;
    logic             w_vld_nxt;
    logic             w_ack_nxt;

    logic             w_req_s;
    logic             w_edge;

    assign w_req_s = r_sync[LEVEL-1];
    assign w_edge  = w_req_s ^ r_req_seen;

    // State and datapath registers
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            r_sync     <= '0;
            r_req_seen <= 1'b0;
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[LEVEL-2:0], req_tgl};
            r_req_seen <= w_seen_nxt;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dout     <= w_dout_nxt;
            r_dout_vld <= w_vld_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    // Next-state logic. Outside IDLE, req_seen tracks req_s so that a toggle
    // arriving mid-transfer is absorbed rather than replayed as a phantom word
    // once the FSM returns to IDLE: one captured word always maps to one ack.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_seen_nxt  = r_req_seen;
        w_dout_nxt  = r_dout;
        w_vld_nxt   = r_dout_vld;
        w_ack_nxt   = r_ack;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_seen_nxt = w_req_s;
                    if (SETTLE == 0) begin
                        w_dout_nxt  = din;
                        w_vld_nxt   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_cnt_nxt   = SETTLE_LD;
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                w_seen_nxt = w_req_s;
                if (r_cnt == 8'd0) begin
                    w_dout_nxt  = din;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_HOLD: begin
                w_seen_nxt = w_req_s;
                if (dout_rdy) begin
                    w_vld_nxt   = 1'b0;
                    w_ack_nxt   = ~r_ack;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef LDL_CDC_HAND_RX_ERR_EN
    logic r_err;

    // A toggle while busy is a foreign-side protocol violation; set beats clear.
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            r_err <= 1'b0;
        end else if ((r_state != S_IDLE) && w_edge) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`endif

    assign ack_tgl  = r_ack;
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;

endmodule

// File: tb/tb_ldl_cdc_hand_rx_v1.sv
module tb_ldl_cdc_hand_rx_v1;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n;
    logic       req_tgl;
    logic [7:0] din;
    logic       ack;
    logic [7:0] dout;
    logic       vld;
    logic       dout_rdy;
    logic       err_clr;
    logic       err;

    logic       req1;
    logic [7:0] din1;
    logic       ack1;
    logic [7:0] dout1;
    logic       vld1;
    logic       err1;

    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];
    logic       exp_ack = 1'b0;
    bit         rnd_rdy = 1'b0;

    always #5 if (clk_run) clk = ~clk;

    ldl_cdc_hand_rx_v1 #(.DW(8), .LEVEL(2), .SETTLE(1)) u_dut (
        .rx_clk  (clk),
        .rx_rst  (rst_n),
        .req_tgl (req_tgl),
        .din     (din),
        .ack_tgl (ack),
        .dout    (dout),
        .dout_vld(vld),
        .dout_rdy(dout_rdy)
`ifdef LDL_CDC_HAND_RX_ERR_EN
        ,
        .err     (err),
        .err_clr (err_clr)
`endif
    );

    ldl_cdc_hand_rx_v1 #(.DW(8), .LEVEL(2), .SETTLE(0)) u_dut0 (
        .rx_clk  (clk),
        .rx_rst  (rst_n),
        .req_tgl (req1),
        .din     (din1),
        .ack_tgl (ack1),
        .dout    (dout1),
        .dout_vld(vld1),
        .dout_rdy(1'b1)
`ifdef LDL_CDC_HAND_RX_ERR_EN
        ,
        .err     (err1),
        .err_clr (1'b0)
`endif
    );

`ifndef LDL_CDC_HAND_RX_ERR_EN
    assign err  = 1'b0;
    assign err1 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted word must match the oldest issued word,
    // and ack must flip exactly once per accepted word.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ack_tgl", {31'b0, ack}, {31'b0, exp_ack});
            if (vld === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_vld", {31'b0, vld}, 32'd0);
                end else begin
                    chk("dout", {24'b0, dout}, {24'b0, q[0]});
                    if (dout_rdy === 1'b1) begin
                        void'(q.pop_front());
                        exp_ack = ~exp_ack;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            dout_rdy = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit wait_ack);
        logic a0;
        int   n;
        a0      = ack;
        din     = d;
        req_tgl = ~req_tgl;
        q.push_back(d);
        if (wait_ack) begin
            n = 0;
            while (ack === a0 && n < 300) begin
                tick(1);
                n++;
            end
            chk("ack_seen", {31'b0, ack !== a0}, 32'd1);
        end
    endtask

    task automatic wait_vld();
        int n;
        n = 0;
        while (vld !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        chk("vld_wait", {31'b0, vld}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b1; req_tgl = 1'b1; din = 8'hFF; dout_rdy = 1'b1; err_clr = 1'b0;
        req1 = 1'b0; din1 = 8'h00;

        // Asynchronous reset with the clock stopped
        #5 rst_n = 1'b0;
        #1;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dout", {24'b0, dout}, 32'd0);
        chk("rst_vld", {31'b0, vld}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_vld_s0", {31'b0, vld1}, 32'd0);
        req_tgl = 1'b0; din = 8'h00;
        clk_run = 1'b1;
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);

        // Single word: valid after edge 4, ack after edge 5
        send(8'hA5, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("lat_vld_e%0d", k), {31'b0, vld}, {31'b0, (k == 4)});
            if (k == 4) chk("lat_dout", {24'b0, dout}, 32'hA5);
            if (k == 5) chk("lat_ack", {31'b0, ack}, 32'd1);
        end
        tick(2);

        // Backpressure for 10 cycles
        dout_rdy = 1'b0;
        send(8'h5A, 1'b0);
        tick(4);
        for (int k = 0; k < 10; k++) begin
            chk("bp_vld", {31'b0, vld}, 32'd1);
            chk("bp_dout", {24'b0, dout}, 32'h5A);
            chk("bp_ack", {31'b0, ack}, 32'd1);
            tick(1);
        end
        dout_rdy = 1'b1;
        tick(1);
        chk("bp_ack_rel", {31'b0, ack}, 32'd0);
        chk("bp_vld_rel", {31'b0, vld}, 32'd0);
        chk("bp_dout_kept", {24'b0, dout}, 32'h5A);
        tick(2);

        // Back-to-back words
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        tick(4);
        chk("b2b_ack_end", {31'b0, ack}, 32'd0);
        chk("b2b_q_empty", q.size(), 32'd0);

        // SETTLE=0 instance: valid after edge 3
        din1 = 8'hC3; req1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("s0_vld_e%0d", k), {31'b0, vld1}, {31'b0, (k == 3)});
        end
        chk("s0_dout", {24'b0, dout1}, 32'hC3);
        tick(2);
        chk("s0_ack", {31'b0, ack1}, 32'd1);
        chk("s0_vld_end", {31'b0, vld1}, 32'd0);

        // Randomized traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick($urandom_range(0, 3));
            send(8'($urandom), 1'b1);
        end
        rnd_rdy = 1'b0;
        tick(2);
        dout_rdy = 1'b1;
        tick(5);
        chk("rnd_q_empty", q.size(), 32'd0);

`ifdef LDL_CDC_HAND_RX_ERR_EN
        // Extra toggle while holding: error, still one word and one ack
        dout_rdy = 1'b0;
        send(8'h3C, 1'b0);
        wait_vld();
        req_tgl = ~req_tgl;
        tick(5);
        chk("err_set", {31'b0, err}, 32'd1);
        dout_rdy = 1'b1;
        tick(10);
        chk("err_q_empty", q.size(), 32'd0);
        chk("err_vld_idle", {31'b0, vld}, 32'd0);
        chk("err_sticky", {31'b0, err}, 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr", {31'b0, err}, 32'd0);
        tick(2);
`endif

        // Reset while holding a word
        dout_rdy = 1'b0;
        send(8'h77, 1'b0);
        wait_vld();
        rst_n = 1'b0;
        #1;
        chk("rsth_vld", {31'b0, vld}, 32'd0);
        chk("rsth_ack", {31'b0, ack}, 32'd0);
        chk("rsth_dout", {24'b0, dout}, 32'd0);
        q.delete();
        exp_ack = 1'b0;
        req_tgl = 1'b0;
        req1 = 1'b0;
        tick(2);
        rst_n = 1'b1;
        dout_rdy = 1'b1;
        tick(20);
        chk("rsth_no_word", {31'b0, vld}, 32'd0);
        chk("rsth_ack_idle", {31'b0, ack}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldl_cdc_hand_rx_v1.md
LDL_CDC_HAND_RX_V1 -- requirements
Module: LDL_cdc_hand_rx_v1

Interface
REQ-001 Parameter DW, 8: data width, 1 or more.
REQ-002 Parameter LEVEL, 2: synchronizer depth on req_tgl, 2 or more.
REQ-003 Parameter SETTLE, 1: rx_clk cycles waited after req edge detect before sampling din, 0..255.
REQ-004 Port rx_clk  input  1: sole clock; one clock, all flops on rising edge.
REQ-005 Port rx_rst  input  1: reset, asynchronous assert, active-low.
REQ-006 Port req_tgl  input  1: 2-phase request toggle from foreign domain, asynchronous to rx_clk.
REQ-007 Port din  input  DW: data from foreign domain, stable from req_tgl toggle until matching ack_tgl toggle.
REQ-008 Port ack_tgl  output  1: 2-phase acknowledge toggle, registered, returned to foreign domain.
REQ-009 Port dout  output  DW: captured data, registered.
REQ-010 Port dout_vld  output  1: dout valid.
REQ-011 Port dout_rdy  input  1: downstream ready.
REQ-012 Port err  output  1: sticky protocol-error flag; exists only under LDL_CDC_HAND_RX_ERR_EN.
REQ-013 Port err_clr  input  1: clears err; exists only under LDL_CDC_HAND_RX_ERR_EN.

Function
REQ-014 req_tgl SHALL pass through a LEVEL-flop synchronizer; its last stage is req_s; no other logic SHALL sample req_tgl.
REQ-015 Register req_seen holds the last accepted req level; edge = (req_s != req_seen).
REQ-016 FSM states IDLE, SETTLE, HOLD; reset state IDLE.
REQ-017 IDLE with edge and SETTLE>0: go to SETTLE, load settle counter with SETTLE-1, req_seen <= req_s.
REQ-018 IDLE with edge and SETTLE=0: capture din into dout, dout_vld <= 1, req_seen <= req_s, go to HOLD in the same edge.
REQ-019 SETTLE: decrement counter each cycle; at counter 0, capture din into dout, dout_vld <= 1, go to HOLD.
REQ-020 Latency: dout_vld rises on rising edge LEVEL+1+SETTLE, counted from the first edge that samples the new req_tgl level.
REQ-021 HOLD: dout and dout_vld held constant while dout_rdy=0; no cycle limit.
REQ-022 HOLD with dout_rdy=1: on that edge dout_vld <= 0, ack_tgl <= ~ack_tgl, go to IDLE; dout keeps its last value.
REQ-023 Exactly one ack_tgl toggle per captured word; ack_tgl never toggles outside the HOLD-to-IDLE transition.
REQ-024 A new edge is only acted on in IDLE; in SETTLE or HOLD it is ignored for data purposes.
REQ-025 Throughput: at most one word per LEVEL+2+SETTLE rx_clk cycles plus the round trip in the foreign domain.

Reset
REQ-026 Reset asserted (rx_rst=0): sync flops, req_seen, ack_tgl, dout, dout_vld, err = 0; FSM = IDLE; settle counter = 0; all effective immediately, without a clock.
REQ-027 Reset mid-transfer discards the word in flight with no ack; the foreign end SHALL be reset together so that both toggles restart at 0.
REQ-028 Release is synchronous-safe: no state changes on the first edge after deassertion other than synchronizer sampling.

Configuration
REQ-029 Macro LDL_CDC_HAND_RX_ERR_EN defined: in SETTLE or HOLD, req_s != req_seen sets err=1 on the next edge; err holds until err_clr=1 on an edge; if set and clear occur on the same edge, set wins.
REQ-030 Macro LDL_CDC_HAND_RX_ERR_EN undefined: err and err_clr ports and their logic are absent; all other behaviour is identical.

Verification (DW=8, LEVEL=2, SETTLE=1 unless stated)
REQ-031 Reset: rx_rst=0 with req_tgl=1 and din=8'hFF -> ack_tgl=0, dout=8'h00, dout_vld=0, err=0 immediately, without a clock.
REQ-032 Single word: din=8'hA5, req_tgl 0->1, dout_rdy=1 -> dout_vld=1 and dout=8'hA5 after edge 4; ack_tgl 0->1 at edge 5; dout_vld=0 after edge 5.
REQ-033 Backpressure: as REQ-032 with dout_rdy=0 for 10 cycles -> dout=8'hA5 and dout_vld=1 held; ack_tgl stays 0; dout_rdy=1 -> ack_tgl toggles on that edge.
REQ-034 Back-to-back: words 8'h11 then 8'h22, foreign end toggling req on each ack -> dout sequence 8'h11, 8'h22; ack_tgl ends at 0; SETTLE=0 run gives dout_vld after edge 3.
REQ-035 Error (macro on): req_tgl toggled twice before dout_rdy -> err=1, one word out, one ack; err_clr=1 for one cycle -> err=0.
REQ-036 Reset in HOLD: rx_rst=0 while dout_vld=1 -> dout_vld=0, ack_tgl=0; after release with req_tgl=0 -> no spurious word.
